// File: rtl/start_token_fanout_fifo_pkg.sv
// Shared widths and reset constants for the start-token fan-out FIFO.
package start_token_fanout_fifo_pkg;

  // Occupancy counter must represent 0..DEPTH inclusive.
  function automatic int count_w(input int addr_width);
    return addr_width + 1;
  endfunction

  function automatic int addr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  localparam logic TAKEN_RST_BIT = 1'b0;

endpackage

// File: rtl/start_token_fanout_fifo_if.sv
// Producer/consumer handshake bundle for the start-token fan-out FIFO.
interface start_token_fanout_fifo_if #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 2,
  parameter int NUM_CONS   = 2
);
  logic                  if_full_n;
  logic                  if_write;
  logic [DATA_WIDTH-1:0] if_din;
  logic [NUM_CONS-1:0]   if_empty_n;
  logic [NUM_CONS-1:0]   if_read;
  logic [DATA_WIDTH-1:0] if_dout;
  logic [ADDR_WIDTH:0]   count;

  modport master (
    output if_write, if_din, if_read,
    input  if_full_n, if_empty_n, if_dout, count
  );

  modport slave (
    input  if_write, if_din, if_read,
    output if_full_n, if_empty_n, if_dout, count
  );
endinterface

// File: rtl/start_token_srl.sv
// Unreset shift-register token store: write shifts into index 0, read is combinational at addr.
module start_token_srl #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 2,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        mem[i] <= mem[i-1];
      end
    end
  end

  assign dout = mem[addr];

endmodule

// File: rtl/start_token_fanout_fifo.sv
// Start-token FIFO broadcasting each head token to NUM_CONS consumers; 1-cycle write-to-visible.
// A token retires in the cycle its last outstanding consumer reads; writes while full are dropped.
module start_token_fanout_fifo
  import start_token_fanout_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 2,
  parameter int DEPTH      = 4,
  parameter int NUM_CONS   = 2
) (
  input  logic                        clk,
  input  logic                        reset_n,
  start_token_fanout_fifo_if.slave    bus
);

  localparam int CW = count_w(ADDR_WIDTH);

  logic [CW-1:0]         count_q;
  logic [NUM_CONS-1:0]   taken_q;
  logic [NUM_CONS-1:0]   empty_n;
  logic [NUM_CONS-1:0]   acc;
  logic [ADDR_WIDTH-1:0] srl_addr;
  logic                  nonempty;
  logic                  full_n;
  logic                  push;
  logic                  pop;

  assign nonempty = (count_q != '0);
  assign full_n   = (count_q != CW'(DEPTH));
  assign empty_n  = {NUM_CONS{nonempty}} & ~taken_q;
  assign acc      = bus.if_read & empty_n;
  assign push     = bus.if_write & full_n;
  // Retire once every consumer has either already taken the head or takes it now.
  assign pop      = nonempty & (&(taken_q | acc));
  assign srl_addr = nonempty ? ADDR_WIDTH'(count_q - 1'b1) : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      taken_q <= {NUM_CONS{TAKEN_RST_BIT}};
    end else begin
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (pop) begin
        taken_q <= {NUM_CONS{TAKEN_RST_BIT}};
      end else begin
        taken_q <= taken_q | acc;
      end
    end
  end

  start_token_srl #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_srl (
    .clk  (clk),
    .we   (push),
    .addr (srl_addr),
    .din  (bus.if_din),
    .dout (bus.if_dout)
  );

  assign bus.if_full_n  = full_n;
  assign bus.if_empty_n = empty_n;
  assign bus.count      = count_q;

endmodule

// File: tb/tb_start_token_fanout_fifo.sv
// Scoreboard bench for start_token_fanout_fifo (DATA_WIDTH=1, DEPTH=4, NUM_CONS=2).
module tb_start_token_fanout_fifo;

  localparam int DW = 1;
  localparam int AW = 2;
  localparam int D  = 4;
  localparam int NC = 2;

  logic clk;
  logic reset_n;

  start_token_fanout_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CONS(NC)) bus ();

  start_token_fanout_fifo #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .DEPTH      (D),
    .NUM_CONS   (NC)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  bit [DW-1:0] m_q[$];
  bit [NC-1:0] m_taken;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Drive one cycle at the falling edge, check outputs, then advance the model with the clock.
  task automatic step(input bit w, input bit [DW-1:0] d, input bit [NC-1:0] r);
    bit [NC-1:0] exp_en;
    bit [NC-1:0] acc;
    bit          pop;
    bit          push;
    bus.if_write = w;
    bus.if_din   = d;
    bus.if_read  = r;
    #1;
    exp_en = (m_q.size() != 0) ? ~m_taken : '0;
    chk("count",   32'(bus.count),      32'(m_q.size()));
    chk("full_n",  32'(bus.if_full_n),  32'(m_q.size() != D));
    chk("empty_n", 32'(bus.if_empty_n), 32'(exp_en));
    acc  = r & exp_en;
    pop  = (m_q.size() != 0) && (&(m_taken | acc));
    push = w && (m_q.size() != D);
    if (pop) begin
      chk("pop_dout", 32'(bus.if_dout), 32'(m_q.pop_front()));
      m_taken = '0;
    end else begin
      if (m_q.size() != 0) chk("head_dout", 32'(bus.if_dout), 32'(m_q[0]));
      m_taken |= acc;
    end
    if (push) m_q.push_back(d);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_count",   32'(bus.count),      32'd0);
    chk("rst_empty_n", 32'(bus.if_empty_n), 32'd0);
    chk("rst_full_n",  32'(bus.if_full_n),  32'd1);
    m_q.delete();
    m_taken = '0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n      = 1'b0;
    bus.if_write = 1'b0;
    bus.if_din   = '0;
    bus.if_read  = '0;
    m_taken      = '0;
    repeat (2) @(negedge clk);
    do_reset();

    // Idle with reads asserted: nothing may change.
    step(0, 0, 2'b11);
    step(0, 0, 2'b11);

    // Single token, consumers read in separate cycles.
    step(1, 1, 2'b00);
    step(0, 0, 2'b01);
    step(0, 0, 2'b00);
    step(0, 0, 2'b10);
    step(0, 0, 2'b00);

    // Fill to full, overflow write dropped, then drain in order.
    step(1, 1, 2'b00);
    step(1, 0, 2'b00);
    step(1, 1, 2'b00);
    step(1, 1, 2'b00);
    step(1, 0, 2'b00);
    for (int i = 0; i < 4; i++) step(0, 0, 2'b11);
    step(0, 0, 2'b00);

    // Full: write with final read is dropped; then write with pop keeps count.
    step(1, 0, 2'b00);
    step(1, 1, 2'b00);
    step(1, 1, 2'b00);
    step(1, 0, 2'b00);
    step(0, 0, 2'b01);
    step(1, 0, 2'b10);
    step(1, 1, 2'b11);
    step(0, 0, 2'b00);
    for (int i = 0; i < 3; i++) step(0, 0, 2'b11);

    // Steady stream: reads tied high, one token per cycle.
    for (int i = 0; i < 20; i++) step(1, DW'($urandom_range(0, 1)), 2'b11);
    for (int i = 0; i < 2; i++) step(0, 0, 2'b11);

    // Mid-stream reset with two tokens held and consumer 0 already served.
    step(1, 1, 2'b00);
    step(1, 0, 2'b00);
    step(0, 0, 2'b01);
    do_reset();
    step(1, 1, 2'b00);
    step(0, 0, 2'b11);
    step(1, 0, 2'b00);
    step(0, 0, 2'b11);

    // Random traffic.
    for (int i = 0; i < 300; i++)
      step(bit'($urandom_range(0, 1)), DW'($urandom_range(0, 1)), NC'($urandom_range(0, 3)));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
